// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - segment codes shared by the scan driver and its encoder
package seg_pkg;

  // Segment vector ordering is {g,f,e,d,c,b,a}, active-high.
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b0111111;
  localparam seg_t SEG_1     = 7'b0000110;
  localparam seg_t SEG_2     = 7'b1011011;
  localparam seg_t SEG_3     = 7'b1001111;
  localparam seg_t SEG_4     = 7'b1100110;
  localparam seg_t SEG_5     = 7'b1101101;
  localparam seg_t SEG_6     = 7'b1111101;
  localparam seg_t SEG_7     = 7'b0000111;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1101111;
  localparam seg_t SEG_A     = 7'b1110111;
  localparam seg_t SEG_B     = 7'b1111100;
  localparam seg_t SEG_C     = 7'b0111001;
  localparam seg_t SEG_D     = 7'b1011110;
  localparam seg_t SEG_E     = 7'b1111001;
  localparam seg_t SEG_F     = 7'b1110001;
  localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_encode.sv
// rtl/seg7_encode.sv - combinational nibble to seven-segment encoder
module seg7_encode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_en,
  output seg_t       seg
);

  // Decimal digits always render; A-F render only when hex display is enabled.
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = hex_en ? SEG_A : SEG_BLANK;
      4'hB: seg = hex_en ? SEG_B : SEG_BLANK;
      4'hC: seg = hex_en ? SEG_C : SEG_BLANK;
      4'hD: seg = hex_en ? SEG_D : SEG_BLANK;
      4'hE: seg = hex_en ? SEG_E : SEG_BLANK;
      4'hF: seg = hex_en ? SEG_F : SEG_BLANK;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed seven-segment scan driver with frame-synchronous update
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int DIV_BITS   = 2,
  parameter bit HEX_EN     = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    load_i,
  input  logic                    blank_lz_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   digit_sel_o,
  output logic                    frame_o,
  output logic                    pending_o
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // Scan timing state
  logic [DIV_BITS-1:0]     prescaler;
  logic [IDX_W-1:0]        scan_idx;

  // Display (currently shown) and shadow (waiting for next frame) registers
  logic [4*NUM_DIGITS-1:0] disp_val;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic [4*NUM_DIGITS-1:0] shadow_val;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic                    pending;

  // Next-state values
  logic                    tick;
  logic                    boundary;
  logic [IDX_W-1:0]        idx_nxt;
  logic [4*NUM_DIGITS-1:0] disp_val_nxt;
  logic [NUM_DIGITS-1:0]   disp_dp_nxt;
  logic [4*NUM_DIGITS-1:0] shadow_val_nxt;
  logic [NUM_DIGITS-1:0]   shadow_dp_nxt;
  logic                    pending_nxt;

  // Next-digit rendering path
  logic [NUM_DIGITS-1:0]   zero_from;
  logic                    zero_acc;
  logic [3:0]              nib_nxt;
  seg_t                    enc_seg;
  logic                    blank_nxt;
  seg_t                    seg_nxt;
  logic                    dp_nxt;
  logic [NUM_DIGITS-1:0]   sel_nxt;

  // Scan tick, frame boundary and the index that the next edge will show
  always_comb begin
    tick     = ena && (&prescaler);
    boundary = tick && (scan_idx == LAST_IDX);
    idx_nxt  = scan_idx;
    if (tick) begin
      idx_nxt = boundary ? '0 : scan_idx + 1'b1;
    end
  end

  // Shadow/display handoff: content only changes on a frame boundary, and a
  // load landing exactly on the boundary goes straight to the display.
  always_comb begin
    disp_val_nxt   = disp_val;
    disp_dp_nxt    = disp_dp;
    shadow_val_nxt = shadow_val;
    shadow_dp_nxt  = shadow_dp;
    pending_nxt    = pending;
    if (boundary && load_i) begin
      disp_val_nxt = value_i;
      disp_dp_nxt  = dp_i;
      pending_nxt  = 1'b0;
    end else if (boundary && pending) begin
      disp_val_nxt = shadow_val;
      disp_dp_nxt  = shadow_dp;
      pending_nxt  = 1'b0;
    end else if (load_i) begin
      shadow_val_nxt = value_i;
      shadow_dp_nxt  = dp_i;
      pending_nxt    = 1'b1;
    end
  end

  // zero_from[k] is set when nibble k and every nibble above it are zero
  always_comb begin
    zero_from = '0;
    zero_acc  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_acc     = zero_acc && (disp_val_nxt[4*k +: 4] == 4'h0);
      zero_from[k] = zero_acc;
    end
  end

  // Select the nibble for the digit shown after the next edge
  always_comb begin
    nib_nxt = disp_val_nxt[4*idx_nxt +: 4];
  end

  seg7_encode u_encode (
    .nibble (nib_nxt),
    .hex_en (HEX_EN),
    .seg    (enc_seg)
  );

  // Apply leading-zero blanking (never on digit 0) and build digit enables
  always_comb begin
    blank_nxt = blank_lz_i && (idx_nxt != '0) && zero_from[idx_nxt];
    seg_nxt   = blank_nxt ? SEG_BLANK : enc_seg;
    dp_nxt    = disp_dp_nxt[idx_nxt];
    sel_nxt   = NUM_DIGITS'(1) << idx_nxt;
  end

  // Prescaler and scan index advance only while enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      scan_idx  <= '0;
    end else if (ena) begin
      prescaler <= prescaler + 1'b1;
      scan_idx  <= idx_nxt;
    end
  end

  // Display, shadow and pending bookkeeping; loads are accepted even when disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_val   <= '0;
      disp_dp    <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
    end else begin
      disp_val   <= disp_val_nxt;
      disp_dp    <= disp_dp_nxt;
      shadow_val <= shadow_val_nxt;
      shadow_dp  <= shadow_dp_nxt;
      pending    <= pending_nxt;
    end
  end

  // Registered outputs move together with the index so they never disagree
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_o       <= SEG_0;
      dp_o        <= 1'b0;
      digit_sel_o <= NUM_DIGITS'(1);
      frame_o     <= 1'b0;
    end else begin
      frame_o <= boundary;
      if (tick) begin
        seg_o       <= seg_nxt;
        dp_o        <= dp_nxt;
        digit_sel_o <= sel_nxt;
      end
    end
  end

  assign pending_o = pending;

endmodule
